trap_ctrl: RTL
==============

# trap_ctrl

Multi-cycle trap sequencer for the machine-mode core. It detects ECALL, EBREAK, MRET and a masked timer interrupt at the decode stage, then holds the pipeline. It drives the CSR write port over successive cycles to update mepc, mstatus and mcause, and finally redirects fetch. It sits between ID, the CSR file and the PC/flush logic.

## Interface

Parameters:
- ADDR_WIDTH, 32, instruction address width
- DATA_WIDTH, 32, CSR data width

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset; asynchronous, active-low
- inst_i  in  32  instruction currently in ID
- inst_addr_i  in  ADDR_WIDTH  address of inst_i
- irq_i  in  1  level-sensitive timer interrupt request
- mstatus_i  in  DATA_WIDTH  current mstatus: bit 3 is MIE, bit 7 is MPIE
- mtvec_i  in  ADDR_WIDTH  trap vector (direct mode)
- mepc_i  in  ADDR_WIDTH  current mepc
- csr_we_o  out  1  CSR write enable
- csr_waddr_o  out  12  CSR write address
- csr_wdata_o  out  DATA_WIDTH  CSR write data
- hold_o  out  1  stall IF/ID/EX
- int_assert_o  out  1  one-cycle redirect and flush strobe
- int_addr_o  out  ADDR_WIDTH  redirect target, valid only while int_assert_o is 1

## Operation

**Event decode in IDLE, highest priority first:**
- inst_i == 0x00000073 (ECALL): cause = 11.
- inst_i == 0x00100073 (EBREAK): cause = 3.
- inst_i == 0x30200073 (MRET).
- irq_i && mstatus_i[3]: cause = 0x80000007.

**Capture on detection edge:**
- epc := inst_addr_i.
- cause := as above.
- mst := mstatus_i.
- For an interrupt, the instruction in ID is not executed; mepc points to it.

**States and transitions:**
- IDLE: trap event -> S_MEPC. MRET -> S_MRET. Otherwise remain in IDLE.
- S_MEPC: write 0x341 <= epc; go to S_MSTATUS.
- S_MSTATUS: write 0x300 <= mst with bit 7 = mst[3] and bit 3 = 0; go to S_MCAUSE.
- S_MCAUSE: write 0x342 <= cause; go to S_JUMP.
- S_MRET: write 0x300 <= mst with bit 3 = mst[7] and bit 7 = 1; go to S_JUMP.
- S_JUMP: int_assert_o = 1. int_addr_o = {mtvec_i[ADDR_WIDTH-1:2], 2'b00} for a trap, or mepc_i for MRET. Go to IDLE.

**Outputs and registers:**
- csr_we_o is 1 only in S_MEPC, S_MSTATUS, S_MCAUSE and S_MRET. When csr_we_o is 0, csr_waddr_o and csr_wdata_o are 0.
- hold_o = (state != IDLE) OR (IDLE and event detected). The second term is combinational, so the detecting instruction never advances to EX.
- A registered `guard` is set in S_JUMP and cleared the next cycle. Event detection is suppressed while guard = 1, which covers the flush bubble.
- Integration contract: int_assert_o flushes IF/ID, so inst_i is a NOP within one cycle.

**Boundary conditions:**
- While state != IDLE, all new events are ignored. irq_i is level-sensitive and is re-sampled on return to IDLE.
- ECALL or EBREAK together with irq_i: take the exception. The interrupt is taken after MRET restores MIE.
- MRET together with irq_i: take MRET first.
- irq_i with MIE = 0: no action and hold_o = 0.
- rst_i low at any time, including mid-sequence: state immediately returns to IDLE and all outputs and registers become 0. A partial CSR sequence is abandoned.

## Timing

- Reset values: csr_we_o, csr_waddr_o, csr_wdata_o, hold_o, int_assert_o and int_addr_o are all 0. state = IDLE, guard = 0.
- Trap detected in cycle N:
  - hold_o is 1 in cycles N..N+4.
  - CSR writes occur in N+1 (mepc), N+2 (mstatus) and N+3 (mcause).
  - int_assert_o is 1 in N+4.
  - IDLE and guard are active in N+5; detection resumes in N+6.
- MRET detected in cycle N:
  - hold_o is 1 in N..N+2.
  - The mstatus write occurs in N+1.
  - int_assert_o is 1 in N+2, with int_addr_o = mepc_i sampled in N+2.
- The CSR file commits writes on the edge ending the write cycle.
- mepc_i and mtvec_i are sampled combinationally in S_JUMP.

## Test plan

- ECALL at 0x00000040, mtvec_i = 0x00000100, mstatus_i = 0x00000008:
  - N+1 writes 0x341 <= 0x40.
  - N+2 writes 0x300 <= 0x80.
  - N+3 writes 0x342 <= 11.
  - N+4 asserts int_assert_o with int_addr_o = 0x100.
- MRET with mepc_i = 0x44, mstatus_i = 0x80:
  - N+1 writes 0x300 <= 0x88.
  - N+2 redirects to 0x44.
  - hold_o is 1 for exactly 3 cycles.
- irq_i = 1 with mstatus_i[3] = 0: no write, hold_o = 0. Then set MIE = 1: a trap occurs with cause 0x80000007 and mepc = the current inst_addr_i.
- ECALL and irq_i asserted together: cause = 11. No second trap starts until the guard cycle after the redirect.
- ECALL sequence with rst_i pulsed low during S_MSTATUS: all outputs are 0 immediately. After release, state is IDLE, with no mcause write and no redirect.
- mtvec_i = 0x00000103: redirect to 0x100, confirming the low two bits are masked.

Source files
------------

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: decode, CSR write port and fetch-redirect signals around trap_ctrl
interface trap_ctrl_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [31:0]           inst_i;
   logic [ADDR_WIDTH-1:0] inst_addr_i;
   logic                  irq_i;
   logic [DATA_WIDTH-1:0] mstatus_i;
   logic [ADDR_WIDTH-1:0] mtvec_i;
   logic [ADDR_WIDTH-1:0] mepc_i;
   logic                  csr_we_o;
   logic [11:0]           csr_waddr_o;
   logic [DATA_WIDTH-1:0] csr_wdata_o;
   logic                  hold_o;
   logic                  int_assert_o;
   logic [ADDR_WIDTH-1:0] int_addr_o;
   modport slave (
      input  inst_i, inst_addr_i, irq_i, mstatus_i, mtvec_i, mepc_i,
      output csr_we_o, csr_waddr_o, csr_wdata_o, hold_o, int_assert_o, int_addr_o
   );
   modport master (
      output inst_i, inst_addr_i, irq_i, mstatus_i, mtvec_i, mepc_i,
      input  csr_we_o, csr_waddr_o, csr_wdata_o, hold_o, int_assert_o, int_addr_o
   );
endinterface

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer writing mepc/mstatus/mcause then redirecting fetch
module trap_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input logic        clk_i,
   input logic        rst_i,
   trap_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, S_MEPC, S_MSTATUS, S_MCAUSE, S_MRET, S_JUMP} state_t;
   state_t                state;
   logic                  guard, is_mret;
   logic [DATA_WIDTH-1:0] mst, cause;
   logic                  det, ecall, ebreak, mret, irq_take, trap, go_mret;
   logic [DATA_WIDTH-1:0] trap_cause;
   assign det        = rst_i && !guard && state == IDLE;
   assign ecall      = bus.inst_i == 32'h0000_0073;
   assign ebreak     = bus.inst_i == 32'h0010_0073;
   assign mret       = bus.inst_i == 32'h3020_0073;
   assign irq_take   = bus.irq_i && bus.mstatus_i[3];
   assign trap       = det && (ecall || ebreak || (irq_take && !mret));
   assign go_mret    = det && mret;
   assign trap_cause = ecall ? DATA_WIDTH'(11) : ebreak ? DATA_WIDTH'(3) : {1'b1, (DATA_WIDTH-1)'(7)};
   assign bus.hold_o     = state != IDLE || trap || go_mret;
   assign bus.int_addr_o = !bus.int_assert_o ? '0 : is_mret ? bus.mepc_i : bus.mtvec_i & ~ADDR_WIDTH'(3);
   // sequencer: each transition preloads the CSR write / redirect outputs of the state it enters
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state            <= IDLE;
         guard            <= 1'b0;
         is_mret          <= 1'b0;
         mst              <= '0;
         cause            <= '0;
         bus.csr_we_o     <= 1'b0;
         bus.csr_waddr_o  <= '0;
         bus.csr_wdata_o  <= '0;
         bus.int_assert_o <= 1'b0;
      end else begin
         bus.csr_we_o     <= 1'b0;
         bus.csr_waddr_o  <= '0;
         bus.csr_wdata_o  <= '0;
         bus.int_assert_o <= 1'b0;
         guard            <= 1'b0;
         case (state)
            IDLE:
               if (trap) begin
                  state           <= S_MEPC;
                  is_mret         <= 1'b0;
                  mst             <= bus.mstatus_i;
                  cause           <= trap_cause;
                  bus.csr_we_o    <= 1'b1;
                  bus.csr_waddr_o <= 12'h341;
                  bus.csr_wdata_o <= DATA_WIDTH'(bus.inst_addr_i);
               end else if (go_mret) begin
                  state           <= S_MRET;
                  is_mret         <= 1'b1;
                  bus.csr_we_o    <= 1'b1;
                  bus.csr_waddr_o <= 12'h300;
                  bus.csr_wdata_o <= {bus.mstatus_i[DATA_WIDTH-1:8], 1'b1, bus.mstatus_i[6:4],
                                      bus.mstatus_i[7], bus.mstatus_i[2:0]};
               end
            S_MEPC: begin
               state           <= S_MSTATUS;
               bus.csr_we_o    <= 1'b1;
               bus.csr_waddr_o <= 12'h300;
               bus.csr_wdata_o <= {mst[DATA_WIDTH-1:8], mst[3], mst[6:4], 1'b0, mst[2:0]};
            end
            S_MSTATUS: begin
               state           <= S_MCAUSE;
               bus.csr_we_o    <= 1'b1;
               bus.csr_waddr_o <= 12'h342;
               bus.csr_wdata_o <= cause;
            end
            S_MCAUSE, S_MRET: begin
               state            <= S_JUMP;
               bus.int_assert_o <= 1'b1;
            end
            S_JUMP: begin
               state <= IDLE;
               guard <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
